// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared types and constants for the instruction-memory loader.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

   // Bytes assembled per instruction word and byte stride between words.
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_STRIDE    = 4;

   // Loader FSM encoding.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_HDR   = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_ERR   = 3'd5;

   // Named view of the same encoding, handy in waveform viewers.
   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      HDR   = ST_HDR,
      DATA  = ST_DATA,
      WRITE = ST_WRITE,
      DONE  = ST_DONE,
      ERR   = ST_ERR
   } state_e;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Purpose  : Byte-stream input handshake plus instruction-memory write port.
// Signals  : in_valid/in_data/in_ready - byte stream (valid/ready)
//            mem_we/mem_addr/mem_wdata - single write port to instr memory
// Modports : master - stream source / memory sink (environment side)
//            slave  - the loader itself
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport master (output in_valid, in_data,
                   input  in_ready, mem_we, mem_addr, mem_wdata);
   modport slave  (input  in_valid, in_data,
                   output in_ready, mem_we, mem_addr, mem_wdata);
endinterface : imem_loader_if
`default_nettype wire

// File: rtl/imem_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : byte_assembler
// Purpose  : Collects 4 stream bytes into a little-endian 32-bit word.
// Ports    : clk, rst  - clock, async active-high reset
//            take_i    - a byte is transferred this cycle
//            clr_i     - restart assembly from byte 0 (wins over take_i)
//            byte_i    - stream byte
//            word_o    - word including the current byte (valid with full_o)
//            full_o    - the 4th byte is taken this cycle
// Revision : 1.0 - initial release
// ============================================================================
module byte_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        take_i,
   input  logic        clr_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        full_o
);

   logic [1:0]  cnt_q, cnt_d;
   // Only the three older bytes need storage: the newest byte comes straight
   // from byte_i so the completed word is available in the cycle of the 4th
   // transfer, which lets the header decision happen without an extra cycle.
   logic [23:0] shift_q, shift_d;

   assign word_o = {byte_i, shift_q};
   assign full_o = take_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (clr_i) begin
         cnt_d   = 2'd0;
         shift_d = 24'd0;
      end else if (take_i) begin
         // Counter wraps to 0 after the 4th byte, ready for the next word.
         cnt_d   = cnt_q + 2'd1;
         shift_d = word_o[31:8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= 2'd0;
         shift_q <= 24'd0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

endmodule : byte_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Fills instruction memory from a byte stream carrying a 32-bit LE
//            word count followed by that many LE instruction words. Holds the
//            core (busy_o) while loading.
// Ports    : clk, rst        - clock, async active-high reset
//            start_i         - one-cycle pulse, begins a load when not busy
//            bus (slave)     - byte stream in, instruction-memory write out
//            busy_o          - load in progress, core PC must be held
//            done_o          - last load completed (sticky until next start)
//            error_o         - last load aborted on bad header (sticky)
//            words_loaded_o  - words written in current/last load
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 256,
   parameter int          CNT_W     = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   imem_loader_if.slave     bus,
   output logic             busy_o,
   output logic             done_o,
   output logic             error_o,
   output logic [CNT_W-1:0] words_loaded_o
);

   logic [2:0]       state_q, state_d;
   logic [31:0]      count_q, count_d;
   logic [31:0]      wdata_q, wdata_d;
   // Also serves as the write index: it equals the index of the next word.
   logic [CNT_W-1:0] words_q, words_d;

   logic        w_ready;
   logic        w_take;
   logic        w_start_ok;
   logic        w_full;
   logic [31:0] w_word;
   logic        w_bad_hdr;
   logic        w_last;
   logic        w_we;

   assign w_ready    = (state_q == ST_HDR) || (state_q == ST_DATA);
   assign w_take     = bus.in_valid && w_ready;
   assign w_start_ok = start_i && ((state_q == ST_IDLE) ||
                                   (state_q == ST_DONE) ||
                                   (state_q == ST_ERR));
   assign w_bad_hdr  = (w_word == 32'd0) || (w_word > 32'(MAX_WORDS));
   assign w_last     = (32'(words_q) == (count_q - 32'd1));
   assign w_we       = (state_q == ST_WRITE);

   byte_assembler u_asm (
      .clk    (clk),
      .rst    (rst),
      .take_i (w_take),
      .clr_i  (w_start_ok),
      .byte_i (bus.in_data),
      .word_o (w_word),
      .full_o (w_full)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      wdata_d = wdata_q;
      words_d = words_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (w_start_ok) begin
               state_d = ST_HDR;
               words_d = '0;
            end
         end
         ST_HDR: begin
            if (w_full) begin
               count_d = w_word;
               state_d = w_bad_hdr ? ST_ERR : ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_full) begin
               wdata_d = w_word;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            words_d = words_q + 1'b1;
            state_d = w_last ? ST_DONE : ST_DATA;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= 32'd0;
         wdata_q <= 32'd0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wdata_q <= wdata_d;
         words_q <= words_d;
      end
   end

   // Address/data are forced to zero outside WRITE so every output reads 0
   // in reset regardless of BASE_ADDR; both are register-driven in WRITE.
   assign bus.in_ready  = w_ready;
   assign bus.mem_we    = w_we;
   assign bus.mem_addr  = w_we ? (BASE_ADDR + 32'(words_q) * 32'(WORD_STRIDE))
                               : 32'd0;
   assign bus.mem_wdata = w_we ? wdata_q : 32'd0;

   assign busy_o         = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                           (state_q == ST_WRITE);
   assign done_o         = (state_q == ST_DONE);
   assign error_o        = (state_q == ST_ERR);
   assign words_loaded_o = words_q;

endmodule : imem_loader
`default_nettype wire
